// File: rtl/md5_wk_feeder.sv
// md5_wk_feeder: buffers one 16-word MD5 block and streams K[i]+M[g(i)] round descriptors
// Ports: clk, reset_n (async, active-low); abort returns to LOAD and drops the block;
//        in_valid/in_ready/in_word load 16 little-endian words, word 0 first;
//        out_valid/out_ready hand over out_wk, out_round, out_quad, out_s_idx, out_last.
module md5_wk_feeder #(
  parameter int START_ROUND = 0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        abort,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_word,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_wk,
  output logic [7:0]  out_round,
  output logic [1:0]  out_quad,
  output logic [3:0]  out_s_idx,
  output logic        out_last
);
  typedef enum logic {LOAD, STREAM} state_e;
  localparam logic [5:0] START = 6'(START_ROUND);
  localparam logic [0:63][31:0] K = {
    32'hd76aa478, 32'he8c7b756, 32'h242070db, 32'hc1bdceee,
    32'hf57c0faf, 32'h4787c62a, 32'ha8304613, 32'hfd469501,
    32'h698098d8, 32'h8b44f7af, 32'hffff5bb1, 32'h895cd7be,
    32'h6b901122, 32'hfd987193, 32'ha679438e, 32'h49b40821,
    32'hf61e2562, 32'hc040b340, 32'h265e5a51, 32'he9b6c7aa,
    32'hd62f105d, 32'h02441453, 32'hd8a1e681, 32'he7d3fbc8,
    32'h21e1cde6, 32'hc33707d6, 32'hf4d50d87, 32'h455a14ed,
    32'ha9e3e905, 32'hfcefa3f8, 32'h676f02d9, 32'h8d2a4c8a,
    32'hfffa3942, 32'h8771f681, 32'h6d9d6122, 32'hfde5380c,
    32'ha4beea44, 32'h4bdecfa9, 32'hf6bb4b60, 32'hbebfbc70,
    32'h289b7ec6, 32'heaa127fa, 32'hd4ef3085, 32'h04881d05,
    32'hd9d4d039, 32'he6db99e5, 32'h1fa27cf8, 32'hc4ac5665,
    32'hf4292244, 32'h432aff97, 32'hab9423a7, 32'hfc93a039,
    32'h655b59c3, 32'h8f0ccc92, 32'hffeff47d, 32'h85845dd1,
    32'h6fa87e4f, 32'hfe2ce6e0, 32'ha3014314, 32'h4e0811a1,
    32'hf7537e82, 32'hbd3af235, 32'h2ad7d2bb, 32'heb86d391
  };
  state_e      state_q, state_d;
  logic [3:0]  load_cnt_q, load_cnt_d;
  logic [5:0]  round_q, round_d;
  logic [31:0] buf_q [16];
  logic [31:0] buf_d [16];
  logic [31:0] wk_q, wk_d;
  logic [3:0]  a, g_d;
  logic        wr, fire;
  assign wr   = !abort && state_q == LOAD && in_valid;
  assign fire = !abort && state_q == STREAM && out_ready;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= LOAD;
      load_cnt_q <= '0;
      round_q    <= START;
      wk_q       <= '0;
    end else begin
      state_q    <= state_d;
      load_cnt_q <= load_cnt_d;
      round_q    <= round_d;
      wk_q       <= wk_d;
    end
  end
  always_ff @(posedge clk) buf_q <= buf_d;
  // wk is computed from the next round and next buffer contents so the
  // descriptor is ready the cycle after the 16th word, even if g hits word 15.
  always_comb begin
    state_d    = abort ? LOAD :
                 (wr && load_cnt_q == 4'd15) ? STREAM :
                 (fire && round_q == 6'd63) ? LOAD : state_q;
    load_cnt_d = abort ? 4'd0 : wr ? load_cnt_q + 4'd1 : load_cnt_q;
    round_d    = abort ? START : fire ? (round_q == 6'd63 ? START : round_q + 6'd1) : round_q;
    buf_d      = buf_q;
    if (wr) buf_d[load_cnt_q] = in_word;
    a          = round_d[3:0];
    g_d        = round_d[5:4] == 2'd0 ? a :
                 round_d[5:4] == 2'd1 ? a * 4'd5 + 4'd1 :
                 round_d[5:4] == 2'd2 ? a * 4'd3 + 4'd5 : a * 4'd7;
    wk_d       = state_d == STREAM ? K[round_d] + buf_d[g_d] : 32'd0;
  end
  always_comb begin
    in_ready  = state_q == LOAD;
    out_valid = state_q == STREAM;
    out_wk    = wk_q;
    out_round = out_valid ? {2'b00, round_q} : 8'd0;
    out_quad  = out_valid ? round_q[5:4] : 2'd0;
    out_s_idx = out_valid ? {round_q[5:4], round_q[1:0]} : 4'd0;
    out_last  = out_valid && round_q == 6'd63;
  end
endmodule

// File: doc/md5_wk_feeder.md
Name: md5_wk_feeder

Overview:
- Stage directly upstream of the MD5 round datapath.
- Accepts one 512-bit message block as 16 little-endian 32-bit words over a valid/ready load port and buffers it.
- Streams one round descriptor per accepted beat: wk = K[i] + M[g(i)], round index, quad function select and rotate-index code. The round datapath adds wk to its running state.

Parameters:
- START_ROUND, 0: first round index streamed, legal 0..63. Rounds below it are precomputed elsewhere and skipped.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- abort  input  1  synchronous clear to LOAD; discards the buffered block.
- in_valid  input  1  in_word is valid.
- in_ready  output  1  block can accept a word.
- in_word  input  32  message word; word 0 arrives first.
- out_valid  output  1  round descriptor is valid.
- out_ready  input  1  downstream consumes the descriptor.
- out_wk  output  32  K[i] + M[g(i)], mod 2^32.
- out_round  output  8  round index i, zero-extended (0..63).
- out_quad  output  2  quad function select, equal to i[5:4].
- out_s_idx  output  4  rotate index code, {i[5:4], i[1:0]}.
- out_last  output  1  high on the round-63 descriptor.

Behaviour:
- Reset (reset_n low, asynchronous):
  - state goes to LOAD, load_cnt=0, round=START_ROUND.
  - in_ready=1, out_valid=0, out_last=0.
  - out_wk, out_round, out_quad, out_s_idx are all 0.
  - Buffer contents are don't-care.
- LOAD state:
  - in_ready=1, out_valid=0.
  - On in_valid&&in_ready: buf[load_cnt]=in_word, then load_cnt increments.
  - On the 16th word (load_cnt==15 accepted): go to STREAM next cycle and set load_cnt=0.
  - Latency: the first out_valid rises on the cycle after the 16th word is accepted.
- STREAM state:
  - in_ready=0; in_valid is ignored.
  - Output registers present the descriptor for the current round.
  - out_valid=1 continuously until the last beat is consumed.
  - On out_valid&&out_ready: round increments and the next descriptor is registered for the following cycle, giving one round per cycle at full throughput.
  - When out_ready=0, all out_* hold stable; no round is skipped or repeated.
  - On acceptance with out_last=1: go to LOAD, round=START_ROUND, out_valid=0 next cycle. in_ready=1 from that same cycle.
  - Descriptors per block: 64-START_ROUND.
- Message index g(i):
  - i 0..15: g=i.
  - i 16..31: g=(5i+1) mod 16.
  - i 32..47: g=(3i+5) mod 16.
  - i 48..63: g=7i mod 16.
- K table:
  - Standard MD5 constants, K[i]=floor(|sin(i+1)|*2^32).
  - Checkpoints: K[0]=d76aa478, K[1]=e8c7b756, K[16]=f61e2562, K[20]=d62f105d, K[48]=f4292244, K[63]=eb86d391.
  - Stored in a constant ROM.
- Arithmetic: out_wk is a 32-bit wraparound sum; carry-out is discarded.
- abort:
  - Takes priority over all handshakes in the same cycle.
  - Next state is LOAD with load_cnt=0, round=START_ROUND, out_valid=0.
  - A word presented in the abort cycle is dropped.
  - Legal in either state.
- Reset mid-operation: immediate return to the reset values above; a partially loaded block is lost.
- Simultaneous last-word acceptance and abort: abort wins and the block is discarded.
- START_ROUND=63: exactly one descriptor per block, with out_last=1.

Test Plan:
- Empty-string block (M[0]=00000080, M[1..15]=0), out_ready=1 throughout. Required: first out_valid the cycle after word 15. Round 0: out_wk=d76aa4f8, out_quad=0, out_s_idx=0. Round 1: out_wk=e8c7b756. Exactly 64 beats, out_last only on round 63.
- Same block, index and constant checks:
  - Round 16: out_wk=f61e2562 (g=1), out_quad=1.
  - Round 20: out_wk=d62f105d (g=5), out_s_idx=4.
  - Round 48: out_wk=f42922c4 (g=0).
  - Round 63: out_wk=eb86d391 (g=9), out_s_idx=15.
- Random out_ready stalls (about 50% duty), M[k]=k*0x01010101. Each round 0..63 appears exactly once, in order. Outputs stay stable across every stall cycle. Each out_wk matches a reference model.
- in_valid gaps during load: 16 words with random idle cycles. load_cnt advances only on accepted words, and the stream is identical to the gap-free load.
- Back-to-back blocks: second block's in_valid held high during streaming. in_ready=0 until the round-63 beat is accepted, then 1. The second block loads correctly and streams from round START_ROUND.
- Disruptions:
  - abort asserted after 7 words: in_ready stays 1 and the next 16 words form a fresh block.
  - abort asserted at round 30: out_valid drops next cycle.
  - reset_n pulsed mid-stream: outputs are 0 immediately, without waiting for a clock edge.
  - START_ROUND=48 build: 16 beats, rounds 48..63.
